// File: rtl/sr_pkg.sv
// Shared SR-storage definitions.
//   st_e     : arbiter FSM state encoding (ARB = waiting for a request,
//              APPLY = driving the granted cell).
//   sr_cmd_e : 2-bit per-cell command (hold / set / reset), reused by other
//              SR-based blocks.
package sr_pkg;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_APPLY = 1'b1
  } st_e;

  typedef enum logic [1:0] {
    SR_HOLD  = 2'b00,
    SR_SET   = 2'b01,
    SR_RESET = 2'b10
  } sr_cmd_e;

  // Map raw S/R inputs onto a command. S=R=1 is illegal and is treated as hold,
  // so a cell can never be driven into an undefined state.
  function automatic sr_cmd_e sr_cmd_from(input logic s, input logic r);
    if (s && !r)      return SR_SET;
    else if (r && !s) return SR_RESET;
    else              return SR_HOLD;
  endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// Single clocked SR flag cell.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset, forces Q=0
//   S    in  set request (Q <= 1)
//   R    in  reset request (Q <= 0)
//   Q    out stored flag
//   Qbar out ~Q at all times
module sr_ff_cell
  import sr_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic S,
  input  logic R,
  output logic Q,
  output logic Qbar
);

  logic    q_q;
  sr_cmd_e cmd;

  always_comb cmd = sr_cmd_from(S, R);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      case (cmd)
        SR_SET:   q_q <= 1'b1;
        SR_RESET: q_q <= 1'b0;
        default:  q_q <= q_q;
      endcase
    end
  end

  assign Q    = q_q;
  assign Qbar = ~q_q;

endmodule

// File: rtl/sr_flag_arbiter.sv
// Bank of NUM_FLAGS SR flags with one update path shared by NUM_REQ requesters
// under round-robin arbitration. One operation per two cycles at most.
// Ports:
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   req        per-requester request valid
//   req_set    per-requester op: 1 = set flag, 0 = reset flag
//   req_idx    per-requester flag index, slot i = [i*IDX_W +: IDX_W]
//   ack        one-hot, one-cycle completion pulse
//   busy       high while the FSM is in APPLY
//   err        one-cycle pulse with ack when the granted index >= NUM_FLAGS
//   Q, Qbar    flag states and their complement
//   dbg_state  current FSM state (ST_ARB / ST_APPLY)
//
// Handshake: req[i] is a valid that the requester holds, together with
// req_set[i] and req_idx slot i, until it sees ack[i]; ack[i] is the one-cycle
// ready/done pulse. During the ack cycle ack[i] masks req[i], so a request
// still asserted in that cycle is not granted a second time. A grant that was
// latched always completes unless reset intervenes.
module sr_flag_arbiter
  import sr_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_FLAGS = 8,
  localparam int IDX_W    = $clog2(NUM_FLAGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       req_set,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     busy,
  output logic                     err,
  output logic [NUM_FLAGS-1:0]     Q,
  output logic [NUM_FLAGS-1:0]     Qbar,
  output logic                     dbg_state
);

  localparam int PTR_W = $clog2(NUM_REQ);

  st_e                  state_q;
  logic [PTR_W-1:0]     rr_ptr_q;
  logic [PTR_W-1:0]     gnt_id_q;
  logic                 gnt_op_q;
  logic [IDX_W-1:0]     gnt_idx_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 err_q;

  logic [NUM_REQ-1:0]   elig;
  logic [NUM_REQ-1:0]   elig_rot;
  logic                 pick_vld;
  logic [PTR_W-1:0]     pick_off;
  logic [PTR_W:0]       pick_sum;
  logic [PTR_W-1:0]     pick_id;
  logic [PTR_W-1:0]     rr_ptr_d;
  logic [NUM_FLAGS-1:0] s_vec;
  logic [NUM_FLAGS-1:0] r_vec;

  // Round-robin pick: rotate eligibility so rr_ptr sits at bit 0, find the
  // lowest set bit, then add rr_ptr back (mod NUM_REQ).
  always_comb begin
    elig     = req & ~ack_q;
    elig_rot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = i + int'(rr_ptr_q);
      if (j >= NUM_REQ) j = j - NUM_REQ;
      elig_rot[i] = elig[j];
    end
    pick_vld = |elig_rot;
    pick_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig_rot[i]) pick_off = PTR_W'(i);
    end
    pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
    if (pick_sum >= (PTR_W+1)'(NUM_REQ)) pick_sum = pick_sum - (PTR_W+1)'(NUM_REQ);
    pick_id = pick_sum[PTR_W-1:0];
  end

  always_comb begin
    if (gnt_id_q == PTR_W'(NUM_REQ - 1)) rr_ptr_d = '0;
    else                                 rr_ptr_d = gnt_id_q + PTR_W'(1);
  end

  // Only the granted cell sees S or R, and only one of them, so S=R=1 can
  // never reach a cell. Out-of-range indices match no cell.
  always_comb begin
    s_vec = '0;
    r_vec = '0;
    for (int f = 0; f < NUM_FLAGS; f++) begin
      if (state_q == ST_APPLY && 32'(gnt_idx_q) == f) begin
        s_vec[f] = gnt_op_q;
        r_vec[f] = ~gnt_op_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ARB;
      rr_ptr_q  <= '0;
      gnt_id_q  <= '0;
      gnt_op_q  <= 1'b0;
      gnt_idx_q <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_ARB: begin
          ack_q <= '0;
          err_q <= 1'b0;
          if (pick_vld) begin
            gnt_id_q  <= pick_id;
            gnt_op_q  <= req_set[pick_id];
            gnt_idx_q <= req_idx[pick_id*IDX_W +: IDX_W];
            state_q   <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          ack_q    <= NUM_REQ'(1) << gnt_id_q;
          err_q    <= (32'(gnt_idx_q) >= NUM_FLAGS);
          rr_ptr_q <= rr_ptr_d;
          state_q  <= ST_ARB;
        end
        default: state_q <= ST_ARB;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_FLAGS; g++) begin : g_cell
    sr_ff_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .S    (s_vec[g]),
      .R    (r_vec[g]),
      .Q    (Q[g]),
      .Qbar (Qbar[g])
    );
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign busy      = (state_q == ST_APPLY);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
module tb_sr_flag_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Main instance: 4 requesters, 8 flags
  logic [3:0]  req = '0, req_set = '0;
  logic [11:0] req_idx = '0;
  logic [3:0]  ack;
  logic        busy, err, dbg;
  logic [7:0]  q, qbar;

  // Second instance: 6 flags, so indices 6 and 7 are out of range
  logic [3:0]  req6 = '0, req_set6 = '0;
  logic [11:0] req_idx6 = '0;
  logic [3:0]  ack6;
  logic        busy6, err6, dbg6;
  logic [5:0]  q6, qbar6;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_flags = '0;

  sr_flag_arbiter #(.NUM_REQ(4), .NUM_FLAGS(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_set(req_set), .req_idx(req_idx),
    .ack(ack), .busy(busy), .err(err), .Q(q), .Qbar(qbar), .dbg_state(dbg)
  );

  sr_flag_arbiter #(.NUM_REQ(4), .NUM_FLAGS(6)) dut6 (
    .clk(clk), .rst(rst), .req(req6), .req_set(req_set6), .req_idx(req_idx6),
    .ack(ack6), .busy(busy6), .err(err6), .Q(q6), .Qbar(qbar6), .dbg_state(dbg6)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // No cell may ever see S and R together
  always @(negedge clk) begin
    if (!rst) begin
      n_vec++;
      if (((dut.s_vec & dut.r_vec) !== 8'h00) || ((dut6.s_vec & dut6.r_vec) !== 6'h00)) begin
        n_err++;
        $display("FAIL sr_exclusive: s&r=%b / %b, required 0", dut.s_vec & dut.r_vec, dut6.s_vec & dut6.r_vec);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst = 1'b1;
    req = '0; req6 = '0;
    exp_flags = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // One complete operation from requester id on the main instance
  task automatic do_op(input int id, input logic op, input logic [2:0] idx);
    req_set[id] = op;
    req_idx[id*3 +: 3] = idx;
    req[id] = 1'b1;
    tick();
    n_vec++; if (busy !== 1'b1 || q !== exp_flags) begin n_err++; $display("FAIL op_apply: busy=%b q=%h, required busy=1 q=%h", busy, q, exp_flags); end
    tick();
    exp_flags[idx] = op;
    n_vec++; if (ack !== 4'(1 << id) || q !== exp_flags || qbar !== ~exp_flags || err !== 1'b0)
      begin n_err++; $display("FAIL op_ack: ack=%b q=%h qbar=%h err=%b, required ack=%b q=%h qbar=%h err=0", ack, q, qbar, err, 4'(1 << id), exp_flags, ~exp_flags); end
    req[id] = 1'b0;
    tick();
    n_vec++; if (ack !== 4'b0 || busy !== 1'b0) begin n_err++; $display("FAIL op_idle: ack=%b busy=%b, required 0/0", ack, busy); end
  endtask

  // All four requesters at once, each on flag i; expected grant order from 'first'
  task automatic run_all(input logic op, input int first);
    for (int i = 0; i < 4; i++) req_idx[i*3 +: 3] = 3'(i);
    req_set = {4{op}};
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      int id;
      id = (first + k) % 4;
      tick();
      n_vec++; if (busy !== 1'b1 || ack !== 4'b0) begin n_err++; $display("FAIL rr_busy k=%0d: busy=%b ack=%b, required 1/0000", k, busy, ack); end
      tick();
      exp_flags[id] = op;
      n_vec++; if (ack !== 4'(1 << id) || q !== exp_flags) begin n_err++; $display("FAIL rr_ack k=%0d: ack=%b q=%h, required ack=%b q=%h", k, ack, q, 4'(1 << id), exp_flags); end
      req[id] = 1'b0;
    end
    tick();
    n_vec++; if (busy !== 1'b0 || ack !== 4'b0) begin n_err++; $display("FAIL rr_done: busy=%b ack=%b, required 0/0000", busy, ack); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (5) tick();
    n_vec++; if (q !== 8'h00 || qbar !== 8'hFF || ack !== 4'b0 || busy !== 1'b0 || err !== 1'b0)
      begin n_err++; $display("FAIL reset_held: q=%h qbar=%h ack=%b busy=%b err=%b, required 00 FF 0000 0 0", q, qbar, ack, busy, err); end
    rst = 1'b0;
    tick();
    n_vec++; if (q !== 8'h00 || qbar !== 8'hFF || ack !== 4'b0 || busy !== 1'b0 || dbg !== 1'b0)
      begin n_err++; $display("FAIL reset_release: q=%h qbar=%h ack=%b busy=%b st=%b, required 00 FF 0000 0 0", q, qbar, ack, busy, dbg); end
    n_vec++; if (q6 !== 6'h00 || qbar6 !== 6'h3F || ack6 !== 4'b0 || busy6 !== 1'b0)
      begin n_err++; $display("FAIL reset6: q=%h qbar=%h ack=%b busy=%b, required 00 3F 0000 0", q6, qbar6, ack6, busy6); end
  endtask

  task automatic test_single();
    do_op(0, 1'b1, 3'd3);
    n_vec++; if (q !== 8'h08) begin n_err++; $display("FAIL single_set: q=%h, required 08", q); end
    do_op(0, 1'b0, 3'd3);
    n_vec++; if (q !== 8'h00) begin n_err++; $display("FAIL single_clr: q=%h, required 00", q); end
    // redundant reset of an already-cleared flag is still acked
    do_op(2, 1'b0, 3'd1);
  endtask

  task automatic test_round_robin();
    apply_reset();
    run_all(1'b1, 0);
    n_vec++; if (q !== 8'h0F) begin n_err++; $display("FAIL rr_round1: q=%h, required 0F", q); end
    do_op(1, 1'b1, 3'd4);   // leaves rr_ptr at 2
    run_all(1'b0, 2);
    n_vec++; if (q !== 8'h10) begin n_err++; $display("FAIL rr_round2: q=%h, required 10", q); end
  endtask

  task automatic test_same_flag();
    do_op(0, 1'b1, 3'd6);   // q=50, rr_ptr=1
    req_set[1] = 1'b1; req_idx[3 +: 3] = 3'd5;
    req_set[2] = 1'b0; req_idx[6 +: 3] = 3'd5;
    req[1] = 1'b1; req[2] = 1'b1;
    tick(); tick();
    n_vec++; if (ack !== 4'b0010 || q !== 8'h70) begin n_err++; $display("FAIL same_first: ack=%b q=%h, required 0010 70", ack, q); end
    req[1] = 1'b0;
    tick(); tick();
    n_vec++; if (ack !== 4'b0100 || q !== 8'h50) begin n_err++; $display("FAIL same_second: ack=%b q=%h, required 0100 50", ack, q); end
    req[2] = 1'b0;
    tick();
    exp_flags = 8'h50;
  endtask

  task automatic test_reset_in_apply();
    req_set[3] = 1'b1; req_idx[9 +: 3] = 3'd7; req[3] = 1'b1;
    tick();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_pre: busy=%b, required 1", busy); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (q !== 8'h00 || qbar !== 8'hFF || busy !== 1'b0 || ack !== 4'b0)
      begin n_err++; $display("FAIL rst_async: q=%h qbar=%h busy=%b ack=%b, required 00 FF 0 0000", q, qbar, busy, ack); end
    tick(); tick();
    n_vec++; if (ack !== 4'b0 || q[7] !== 1'b0) begin n_err++; $display("FAIL rst_noack: ack=%b q=%h, required 0000 q[7]=0", ack, q); end
    rst = 1'b0;
    tick();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_regrant: busy=%b, required 1", busy); end
    tick();
    n_vec++; if (ack !== 4'b1000 || q !== 8'h80) begin n_err++; $display("FAIL rst_done: ack=%b q=%h, required 1000 80", ack, q); end
    req[3] = 1'b0;
    tick();
  endtask

  task automatic test_err_and_hold();
    // valid set of flag 2 on the 6-flag instance
    req_set6[0] = 1'b1; req_idx6[2:0] = 3'd2; req6[0] = 1'b1;
    tick(); tick();
    n_vec++; if (ack6 !== 4'b0001 || q6 !== 6'h04 || err6 !== 1'b0) begin n_err++; $display("FAIL err_setup: ack=%b q=%h err=%b, required 0001 04 0", ack6, q6, err6); end
    req6[0] = 1'b0;
    tick();
    // out-of-range index 7
    req_idx6[2:0] = 3'd7; req6[0] = 1'b1;
    tick();
    n_vec++; if (busy6 !== 1'b1 || err6 !== 1'b0) begin n_err++; $display("FAIL err_apply: busy=%b err=%b, required 1 0", busy6, err6); end
    tick();
    n_vec++; if (ack6 !== 4'b0001 || err6 !== 1'b1 || q6 !== 6'h04 || qbar6 !== 6'h3B)
      begin n_err++; $display("FAIL err_pulse: ack=%b err=%b q=%h qbar=%h, required 0001 1 04 3B", ack6, err6, q6, qbar6); end
    // req held one cycle past ack: must not be granted again
    tick();
    n_vec++; if (busy6 !== 1'b0 || ack6 !== 4'b0 || err6 !== 1'b0) begin n_err++; $display("FAIL no_double: busy=%b ack=%b err=%b, required 0 0000 0", busy6, ack6, err6); end
    req6[0] = 1'b0;
    tick();
    n_vec++; if (busy6 !== 1'b0 || q6 !== 6'h04) begin n_err++; $display("FAIL err_idle: busy=%b q=%h, required 0 04", busy6, q6); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_same_flag();
    test_reset_in_apply();
    test_err_and_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
